cpu_clk_ctrl: RTL and testbench

Consumer side of the board clock divider. It turns the free-running system clock into a single-cycle CPU clock-enable pulse, cpu_ce. Four modes are supported: fast run, slow run (human-visible), debounced single-step from a push button, and halt. Mode changes are glitch-free, so the CPU never sees a truncated or doubled enable period. The block sits between the top-level clock/switch inputs and the CPU datapath's enable input.

---
 rtl/cpu_clk_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: derives a one-cycle CPU clock-enable pulse from the system
// clock. Supports fast run, slow run, debounced single-step and halt modes.
// Mode changes take effect only on period boundaries, or immediately from
// step/halt, so the CPU never sees a truncated or doubled enable period.
module cpu_clk_ctrl #(
    parameter int FAST_DIV   = 4,
    parameter int SLOW_DIV   = 134217728,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic        step_btn,
    output logic        cpu_ce,
    output logic [1:0]  active_mode,
    output logic [31:0] ce_count,
    output logic        btn_level
);

    localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int DIV_W   = $clog2(MAX_DIV);
    localparam int DEB_W   = $clog2(DEB_CYCLES);

    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

    // State encoding matches the mode switch encoding, so the synchronized
    // mode can be used directly as the target state.
    typedef enum logic [1:0] {
        RUN_FAST  = 2'b00,
        RUN_SLOW  = 2'b01,
        STEP_WAIT = 2'b10,
        HALT      = 2'b11
    } state_t;

    // Synchronizer flops
    logic [1:0]       mode_meta_reg;
    logic [1:0]       mode_s_reg;
    logic             btn_meta_reg;
    logic             btn_s_reg;

    // Debounce
    logic [DEB_W-1:0] deb_cnt_reg;
    logic [DEB_W-1:0] deb_cnt_next;
    logic             btn_level_reg;
    logic             btn_level_next;
    logic             btn_prev_reg;

    // Core FSM and divider
    state_t           state_reg;
    state_t           state_next;
    state_t           mode_state;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic [DIV_W-1:0] div_last;
    logic             cpu_ce_reg;
    logic             cpu_ce_next;
    logic             step_arm_reg;
    logic             step_arm_next;
    logic             btn_rise;
    logic [31:0]      ce_count_reg;
    logic [31:0]      ce_count_next;

    // Two-flop synchronizers for the asynchronous switch and button inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_meta_reg <= 2'b00;
            mode_s_reg    <= 2'b00;
            btn_meta_reg  <= 1'b0;
            btn_s_reg     <= 1'b0;
        end else begin
            mode_meta_reg <= mode;
            mode_s_reg    <= mode_meta_reg;
            btn_meta_reg  <= step_btn;
            btn_s_reg     <= btn_meta_reg;
        end
    end

    // Debounce: accept a new button level only after it has held DEB_CYCLES cycles
    always_comb begin
        deb_cnt_next   = deb_cnt_reg;
        btn_level_next = btn_level_reg;
        if (btn_s_reg == btn_level_reg) begin
            deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
            btn_level_next = btn_s_reg;
            deb_cnt_next   = '0;
        end else begin
            deb_cnt_next = deb_cnt_reg + 1'b1;
        end
    end

    assign mode_state = state_t'(mode_s_reg);
    assign div_last   = (state_reg == RUN_SLOW) ? SLOW_LAST : FAST_LAST;
    assign btn_rise   = btn_level_reg & ~btn_prev_reg;

    // Next-state, divider and pulse generation
    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        cpu_ce_next   = 1'b0;
        // The arm flag is only set after a full cycle spent in STEP_WAIT, so a
        // level rise that happened before entry can never fire a step.
        step_arm_next = (state_reg == STEP_WAIT);
        case (state_reg)
            RUN_FAST, RUN_SLOW: begin
                if (div_cnt_reg == div_last) begin
                    // Boundary: pulse under the old mode, then switch if requested
                    div_cnt_next = '0;
                    cpu_ce_next  = 1'b1;
                    state_next   = mode_state;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            STEP_WAIT: begin
                div_cnt_next = '0;
                // A mode change wins over a simultaneous step edge
                if (mode_state != STEP_WAIT) begin
                    state_next = mode_state;
                end else if (btn_rise && step_arm_reg) begin
                    cpu_ce_next = 1'b1;
                end
            end
            HALT: begin
                div_cnt_next = '0;
                if (mode_state != HALT) begin
                    state_next = mode_state;
                end
            end
            default: begin
                state_next   = RUN_FAST;
                div_cnt_next = '0;
            end
        endcase
    end

    // Pulse counter wraps naturally at 32 bits
    always_comb begin
        ce_count_next = ce_count_reg;
        if (cpu_ce_reg) begin
            ce_count_next = ce_count_reg + 32'd1;
        end
    end

    // State registers for FSM, divider, debounce and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN_FAST;
            div_cnt_reg   <= '0;
            cpu_ce_reg    <= 1'b0;
            step_arm_reg  <= 1'b0;
            deb_cnt_reg   <= '0;
            btn_level_reg <= 1'b0;
            btn_prev_reg  <= 1'b0;
            ce_count_reg  <= 32'd0;
        end else begin
            state_reg     <= state_next;
            div_cnt_reg   <= div_cnt_next;
            cpu_ce_reg    <= cpu_ce_next;
            step_arm_reg  <= step_arm_next;
            deb_cnt_reg   <= deb_cnt_next;
            btn_level_reg <= btn_level_next;
            btn_prev_reg  <= btn_level_reg;
            ce_count_reg  <= ce_count_next;
        end
    end

    assign cpu_ce      = cpu_ce_reg;
    assign active_mode = state_reg;
    assign ce_count    = ce_count_reg;
    assign btn_level   = btn_level_reg;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed testbench for cpu_clk_ctrl with small divider/debounce values.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_cpu_clk_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        step_btn;
    logic        cpu_ce;
    logic [1:0]  active_mode;
    logic [31:0] ce_count;
    logic        btn_level;

    int checks;
    int failures;

    cpu_clk_ctrl #(
        .FAST_DIV   (4),
        .SLOW_DIV   (16),
        .DEB_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .step_btn    (step_btn),
        .cpu_ce      (cpu_ce),
        .active_mode (active_mode),
        .ce_count    (ce_count),
        .btn_level   (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        mode     = 2'b00;
        step_btn = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("reset_active_mode", 32'(active_mode), 32'd0);
        chk("reset_ce_count", ce_count, 32'd0);
        chk("reset_btn_level", 32'(btn_level), 32'd0);
        $display("step: reset checked");
        rst = 1'b0;

        // Fast mode: pulse after every 4th edge following release
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            chk("fast_cpu_ce", 32'(cpu_ce), 32'((n % 4) == 0));
        end
        chk("fast_ce_count", ce_count, 32'd9);
        chk("fast_active_mode", 32'(active_mode), 32'd0);
        $display("step: fast run, 40 cycles");

        // Request slow mode while div_cnt=1; switch at the next boundary (edge 44)
        @(negedge clk);
        mode = 2'b01;
        chk("fs_cpu_ce_41", 32'(cpu_ce), 32'd0);
        for (int n = 42; n <= 76; n++) begin
            @(negedge clk);
            chk("fs_cpu_ce", 32'(cpu_ce),
                (n <= 44) ? 32'((n % 4) == 0) : 32'(((n - 44) % 16) == 0));
            chk("fs_active_mode", 32'(active_mode), (n >= 44) ? 32'd1 : 32'd0);
        end
        $display("step: fast to slow switch");

        // Request single-step; leaves slow mode at the next slow boundary (edge 92)
        mode = 2'b10;
        for (int n = 77; n <= 92; n++) begin
            @(negedge clk);
            chk("ss_cpu_ce", 32'(cpu_ce), 32'(n == 92));
            chk("ss_active_mode", 32'(active_mode), (n >= 92) ? 32'd2 : 32'd1);
        end
        @(negedge clk);
        chk("ss_ce_count", ce_count, 32'd14);
        chk("ss_idle_cpu_ce", 32'(cpu_ce), 32'd0);
        $display("step: slow to single-step switch");

        // Bouncing button, 3-cycle phases, never long enough to be accepted
        for (int ph = 0; ph < 6; ph++) begin
            step_btn = ((ph % 2) == 0);
            repeat (3) begin
                @(negedge clk);
                chk("bounce_btn_level", 32'(btn_level), 32'd0);
                chk("bounce_cpu_ce", 32'(cpu_ce), 32'd0);
            end
        end
        // Stable press: level accepted 10 cycles later, one pulse the cycle after
        step_btn = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            chk("press_btn_level", 32'(btn_level), 32'(k >= 10));
            chk("press_cpu_ce", 32'(cpu_ce), 32'(k == 11));
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("hold_cpu_ce", 32'(cpu_ce), 32'd0);
        end
        chk("hold_ce_count", ce_count, 32'd15);
        $display("step: debounced press and hold");

        // Release, then press again for one more pulse
        step_btn = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("release_btn_level", 32'(btn_level), 32'(k < 10));
            chk("release_cpu_ce", 32'(cpu_ce), 32'd0);
        end
        step_btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("repress_cpu_ce", 32'(cpu_ce), 32'(k == 11));
        end
        chk("repress_ce_count", ce_count, 32'd16);
        $display("step: release and second press");

        // Halt: state changes on the first cycle the synced mode differs
        mode = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("halt_entry_mode", 32'(active_mode), (k >= 3) ? 32'd3 : 32'd2);
            chk("halt_entry_cpu_ce", 32'(cpu_ce), 32'd0);
        end
        for (int k = 0; k < 200; k++) begin
            step_btn = (((k / 30) % 2) == 1);
            @(negedge clk);
            chk("halt_cpu_ce", 32'(cpu_ce), 32'd0);
        end
        chk("halt_ce_count", ce_count, 32'd16);
        chk("halt_active_mode", 32'(active_mode), 32'd3);
        $display("step: halt with button activity");

        // Counter wrap: preload all-ones while halted, then one fast pulse
        force dut.ce_count_reg = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.ce_count_reg;
        @(negedge clk);
        chk("wrap_preload", ce_count, 32'hFFFF_FFFF);
        mode = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("wrap_cpu_ce", 32'(cpu_ce), 32'(k == 7));
            chk("wrap_active_mode", 32'(active_mode), (k >= 3) ? 32'd0 : 32'd3);
        end
        chk("wrap_ce_count", ce_count, 32'd0);
        $display("step: ce_count wrap");

        // Switch to slow, then reset at div_cnt=2
        mode = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("pre_rst_cpu_ce", 32'(cpu_ce), 32'(k == 3));
            chk("pre_rst_active_mode", 32'(active_mode), (k >= 3) ? 32'd1 : 32'd0);
        end
        rst  = 1'b1;
        mode = 2'b00;
        @(negedge clk);
        chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("rst_active_mode", 32'(active_mode), 32'd0);
        chk("rst_ce_count", ce_count, 32'd0);
        chk("rst_btn_level", 32'(btn_level), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("post_rst_cpu_ce", 32'(cpu_ce), 32'(k == 4));
        end
        $display("step: mid-period reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
